// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch FSM, MM:SS.t BCD count and lap-freeze display mux
// Optional feature macro: STOPWATCH_AUTO_STOP_EN (hold at MAX_MIN:59.9 and force STOP)
module stopwatch_ctrl #(
  parameter int unsigned MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_100ms,
  input  logic       btn_ss,
  input  logic       btn_lc,
  output logic       run,
  output logic       clr_tick,
  output logic       lap_hold,
  output logic       overflow,
  output logic [3:0] disp_t,
  output logic [3:0] disp_s0,
  output logic [3:0] disp_s1,
  output logic [3:0] disp_m0,
  output logic [3:0] disp_m1
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAP  = 2'd2,
    S_STOP = 2'd3
  } state_e;

  localparam logic [3:0] MAX_M1 = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_M0 = 4'(MAX_MIN % 10);

  // Count and snapshot are packed as {m1, m0, s1, s0, t}.
  state_e      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [19:0] snap_q, snap_d;
  logic        ovf_q, ovf_d;

  logic [19:0] cnt_inc;
  logic        at_max;
  logic        count_en;

  // BCD ripple increment of the live count and detection of the last value.
  always_comb begin
    cnt_inc = cnt_q;
    at_max  = (cnt_q[19:16] == MAX_M1) && (cnt_q[15:12] == MAX_M0) &&
              (cnt_q[11:8] == 4'd5) && (cnt_q[7:4] == 4'd9) && (cnt_q[3:0] == 4'd9);
    if (cnt_q[3:0] != 4'd9) begin
      cnt_inc[3:0] = cnt_q[3:0] + 4'd1;
    end else begin
      cnt_inc[3:0] = 4'd0;
      if (cnt_q[7:4] != 4'd9) begin
        cnt_inc[7:4] = cnt_q[7:4] + 4'd1;
      end else begin
        cnt_inc[7:4] = 4'd0;
        if (cnt_q[11:8] != 4'd5) begin
          cnt_inc[11:8] = cnt_q[11:8] + 4'd1;
        end else begin
          cnt_inc[11:8] = 4'd0;
          if (cnt_q[15:12] != 4'd9) begin
            cnt_inc[15:12] = cnt_q[15:12] + 4'd1;
          end else begin
            cnt_inc[15:12] = 4'd0;
            cnt_inc[19:16] = (cnt_q[19:16] == 4'd9) ? 4'd0 : cnt_q[19:16] + 4'd1;
          end
        end
      end
    end
  end

  // Next-state, count, snapshot and overflow; btn_ss takes priority over btn_lc.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    snap_d   = snap_q;
    ovf_d    = ovf_q;
    clr_tick = 1'b0;
    count_en = ((state_q == S_RUN) || (state_q == S_LAP)) && tick_100ms;

    if (count_en) begin
      if (at_max) begin
        ovf_d = 1'b1;
`ifndef STOPWATCH_AUTO_STOP_EN
        cnt_d = '0;
`endif
      end else begin
        cnt_d = cnt_inc;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (btn_ss) begin
          state_d  = S_RUN;
          clr_tick = 1'b1;
        end
      end
      S_RUN: begin
        if (btn_ss) begin
          state_d = S_STOP;
        end else if (btn_lc) begin
          state_d = S_LAP;
          snap_d  = cnt_d;
        end
      end
      S_LAP: begin
        if (btn_ss) begin
          state_d = S_STOP;
        end else if (btn_lc) begin
          state_d = S_RUN;
        end
      end
      S_STOP: begin
        if (btn_ss) begin
`ifdef STOPWATCH_AUTO_STOP_EN
          if (!ovf_q) begin
            state_d = S_RUN;
          end
`else
          state_d = S_RUN;
`endif
        end else if (btn_lc) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef STOPWATCH_AUTO_STOP_EN
    // Reaching the end of range overrides any button in the same cycle.
    if (count_en && at_max) begin
      state_d = S_STOP;
    end
`endif
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      snap_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign run      = (state_q == S_RUN) || (state_q == S_LAP);
  assign lap_hold = (state_q == S_LAP);
  assign overflow = ovf_q;
  assign {disp_m1, disp_m0, disp_s1, disp_s0, disp_t} = lap_hold ? snap_q : cnt_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - scoreboard bench for stopwatch_ctrl against a tenths-count model
module tb_stopwatch_ctrl;

  localparam int unsigned MAX_MIN = 1;
  localparam int          MAX_CNT = MAX_MIN * 600 + 599;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_100ms = 1'b0;
  logic       btn_ss = 1'b0;
  logic       btn_lc = 1'b0;
  logic       run, clr_tick, lap_hold, overflow;
  logic [3:0] disp_t, disp_s0, disp_s1, disp_m0, disp_m1;

  stopwatch_ctrl #(.MAX_MIN(MAX_MIN)) dut (
    .clk(clk), .rst(rst), .tick_100ms(tick_100ms), .btn_ss(btn_ss), .btn_lc(btn_lc),
    .run(run), .clr_tick(clr_tick), .lap_hold(lap_hold), .overflow(overflow),
    .disp_t(disp_t), .disp_s0(disp_s0), .disp_s1(disp_s1), .disp_m0(disp_m0), .disp_m1(disp_m1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        run;
    logic        clr;
    logic        lap;
    logic        ovf;
    logic [19:0] disp;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err = 0;

  typedef enum {M_IDLE, M_RUN, M_LAP, M_STOP} mstate_t;
  mstate_t m_st = M_IDLE;
  int      m_cnt = 0;
  int      m_snap = 0;
  bit      m_ovf = 1'b0;

  function automatic logic [19:0] to_bcd(input int c);
    int secs;
    int mins;
    secs = (c / 10) % 60;
    mins = c / 600;
    return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10), 4'(c % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  task automatic model_reset();
    m_st   = M_IDLE;
    m_cnt  = 0;
    m_snap = 0;
    m_ovf  = 1'b0;
  endtask

  // One clock of stimulus: expectation for this cycle is queued, then the model advances.
  task automatic step(input bit ss, input bit lc, input bit tk);
    exp_t e;
    int   nxt;
    @(posedge clk);
    #2;
    btn_ss     = ss;
    btn_lc     = lc;
    tick_100ms = tk;
    e.run  = (m_st == M_RUN) || (m_st == M_LAP);
    e.lap  = (m_st == M_LAP);
    e.clr  = (m_st == M_IDLE) && ss;
    e.ovf  = m_ovf;
    e.disp = to_bcd(e.lap ? m_snap : m_cnt);
    exp_q.push_back(e);

    nxt = m_cnt;
    if (e.run && tk) begin
      if (m_cnt == MAX_CNT) begin
        m_ovf = 1'b1;
`ifdef STOPWATCH_AUTO_STOP_EN
        m_st = M_STOP;
        return;
`else
        nxt = 0;
`endif
      end else begin
        nxt = m_cnt + 1;
      end
    end
    m_cnt = nxt;

    if (ss) begin
      case (m_st)
        M_IDLE: m_st = M_RUN;
        M_RUN:  m_st = M_STOP;
        M_LAP:  m_st = M_STOP;
        M_STOP: begin
`ifdef STOPWATCH_AUTO_STOP_EN
          if (!m_ovf) m_st = M_RUN;
`else
          m_st = M_RUN;
`endif
        end
        default: m_st = M_IDLE;
      endcase
    end else if (lc) begin
      case (m_st)
        M_RUN: begin
          m_st   = M_LAP;
          m_snap = m_cnt;
        end
        M_LAP:  m_st = M_RUN;
        M_STOP: begin
          m_st  = M_IDLE;
          m_cnt = 0;
          m_ovf = 1'b0;
        end
        default: ;
      endcase
    end
  endtask

  // Monitor: every mid-cycle sample with a pending expectation is compared.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("ctrl{run,clr_tick,lap_hold,overflow}", 32'({run, clr_tick, lap_hold, overflow}),
              32'({e.run, e.clr, e.lap, e.ovf}));
        check("disp{m1,m0,s1,s0,t}", 32'({disp_m1, disp_m0, disp_s1, disp_s0, disp_t}), 32'(e.disp));
      end
    end
  end

  initial begin
    int waited;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", 32'({run, clr_tick, lap_hold, overflow}), 32'h0);
    check("reset_disp", 32'({disp_m1, disp_m0, disp_s1, disp_s0, disp_t}), 32'h0);
    #2 rst = 1'b1;

    // Start and count to 00:02.5, then to 00:03.0.
    step(1'b1, 1'b0, 1'b0);
    repeat (25) step(1'b0, 1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0, 1'b1);
    // Lap freeze at 00:03.0 while counting continues, then release.
    step(1'b0, 1'b1, 1'b0);
    repeat (7) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    // Stop with a simultaneous tick at 00:04.4, ignored ticks, restart with both buttons.
    repeat (7) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    // Run through 00:09.9, 00:59.9 and up to the end of range, then one more tick.
    while (m_cnt != MAX_CNT) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-run at 00:12.3.
    step(1'b1, 1'b0, 1'b0);
    repeat (123) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("async_rst_ctrl", 32'({run, clr_tick, lap_hold, overflow}), 32'h0);
    check("async_rst_disp", 32'({disp_m1, disp_m0, disp_s1, disp_s0, disp_t}), 32'h0);
    @(posedge clk);
    #4 rst = 1'b1;
    model_reset();
    repeat (3) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);

    // Randomized button and tick traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)));
    end
    step(1'b0, 1'b0, 1'b0);

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
